// File: rtl/u_dly_code_ctrl_pkg.sv
// Shared definitions for the delay-code loop controller: FSM state encodings
// and step-direction encodings.
package u_dly_code_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle   = 2'd0;
    localparam state_t StSettle = 2'd1;
    localparam state_t StTrack  = 2'd2;

    localparam logic DirDn = 1'b0;
    localparam logic DirUp = 1'b1;

endpackage

// File: rtl/u_dly_code_ctrl_filt.sv
// Signed up/down accumulator for phase-detector samples. The step pulses are
// decoded from the current accumulator value and the present sample, so the
// code register in the parent can move on the same edge that consumes the
// threshold-reaching sample.
module u_dly_code_ctrl_filt #(
    parameter int unsigned FILT_TH = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    input  logic up_i,
    input  logic dn_i,
    output logic step_up_o,
    output logic step_dn_o
);

    localparam int unsigned AW = $clog2(FILT_TH + 1) + 1;

    localparam logic signed [AW-1:0] AccHi = AW'(FILT_TH - 1);
    localparam logic signed [AW-1:0] AccLo = -AccHi;
    localparam logic signed [AW-1:0] One   = 1;

    logic signed [AW-1:0] acc_q, acc_d;
    logic inc, dec;

    // Both or neither PD input asserted carries no information.
    assign inc = up_i & ~dn_i;
    assign dec = dn_i & ~up_i;

    // Threshold is reached when the stored value is one short and the sample agrees.
    always_comb begin
        step_up_o = en_i & ~clr_i & inc & (acc_q == AccHi);
        step_dn_o = en_i & ~clr_i & dec & (acc_q == AccLo);
    end

    // Accumulate while enabled; a step or an external clear empties it.
    always_comb begin
        acc_d = acc_q;
        if (clr_i || step_up_o || step_dn_o) begin
            acc_d = '0;
        end else if (en_i && inc) begin
            acc_d = acc_q + One;
        end else if (en_i && dec) begin
            acc_d = acc_q - One;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/u_dly_code_ctrl.sv
// Delay-code loop controller: filters lead/lag samples, steps a saturating
// code, drives the fine-cell thermometer selects and reports lock/saturation.
module u_dly_code_ctrl
    import u_dly_code_ctrl_pkg::*;
#(
    parameter int unsigned N_FINE     = 16,
    parameter int unsigned INIT_CODE  = 8,
    parameter int unsigned FILT_TH    = 4,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned LOCK_REV   = 4,
    localparam int unsigned CW        = $clog2(N_FINE + 1)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_en,
    input  logic              i_init,
    input  logic              i_pd_up,
    input  logic              i_pd_dn,
    output logic [N_FINE-1:0] o_sel,
    output logic [CW-1:0]     o_code,
    output logic              o_lock,
    output logic              o_sat
);

    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned RW = $clog2(LOCK_REV + 1);

    localparam logic [CW-1:0] CodeInit = CW'(INIT_CODE);
    localparam logic [CW-1:0] CodeMax  = CW'(N_FINE);
    localparam logic [CW-1:0] CodeOne  = CW'(1);
    localparam logic [SW-1:0] SettleLast = SW'(SETTLE_CYC - 1);
    localparam logic [RW-1:0] RevMax   = RW'(LOCK_REV);

    function automatic logic [N_FINE-1:0] thermo(input logic [CW-1:0] c);
        logic [N_FINE-1:0] t;
        for (int k = 0; k < N_FINE; k++) begin
            t[k] = (int'(c) > k);
        end
        return t;
    endfunction

    state_t            state_q, state_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [CW-1:0]     code_q, code_d;
    logic [N_FINE-1:0] sel_q, sel_d;
    logic [RW-1:0]     rev_q, rev_d;
    logic              last_vld_q, last_vld_d;
    logic              last_dir_q, last_dir_d;
    logic              sat_q, sat_d;
    logic              sat_dir_q, sat_dir_d;

    logic step_up, step_dn;
    logic filt_en, filt_clr;
    logic real_up, real_dn, real_step, step_dir;
    logic sat_up, sat_dn;

    assign filt_en  = (state_q == StTrack) & i_en;
    assign filt_clr = i_init | ~i_en;

    u_dly_code_ctrl_filt #(
        .FILT_TH (FILT_TH)
    ) u_filt (
        .clk_i     (i_clk),
        .rst_ni    (i_rstn),
        .en_i      (filt_en),
        .clr_i     (filt_clr),
        .up_i      (i_pd_up),
        .dn_i      (i_pd_dn),
        .step_up_o (step_up),
        .step_dn_o (step_dn)
    );

    // Split filter steps into real code moves and rail hits.
    always_comb begin
        real_up   = step_up & (code_q != CodeMax);
        real_dn   = step_dn & (code_q != '0);
        sat_up    = step_up & (code_q == CodeMax);
        sat_dn    = step_dn & (code_q == '0);
        real_step = real_up | real_dn;
        step_dir  = real_up ? DirUp : DirDn;
    end

    // Next-state for FSM, code, lock and saturation; i_init outranks everything.
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        code_d     = code_q;
        rev_d      = rev_q;
        last_vld_d = last_vld_q;
        last_dir_d = last_dir_q;
        sat_d      = sat_q;
        sat_dir_d  = sat_dir_q;

        if (i_init) begin
            code_d     = CodeInit;
            rev_d      = '0;
            sat_d      = 1'b0;
            last_vld_d = 1'b0;
            settle_d   = '0;
            state_d    = i_en ? StSettle : StIdle;
        end else if (!i_en) begin
            state_d  = StIdle;
            settle_d = '0;
            rev_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d  = StSettle;
                    settle_d = '0;
                end
                StSettle: begin
                    if (settle_q == SettleLast) begin
                        state_d  = StTrack;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end
                StTrack: begin
                    if (real_step) begin
                        code_d   = real_up ? code_q + CodeOne : code_q - CodeOne;
                        state_d  = StSettle;
                        settle_d = '0;
                        if (last_vld_q && (last_dir_q != step_dir)) begin
                            rev_d = (rev_q == RevMax) ? rev_q : rev_q + RW'(1);
                        end else begin
                            rev_d = '0;
                        end
                        last_vld_d = 1'b1;
                        last_dir_d = step_dir;
                        if (sat_q && (sat_dir_q != step_dir)) begin
                            sat_d = 1'b0;
                        end
                    end else if (sat_up || sat_dn) begin
                        // Rail hit: code held, loop keeps tracking without settling.
                        sat_d     = 1'b1;
                        sat_dir_d = sat_up ? DirUp : DirDn;
                    end
                end
                default: begin
                    state_d  = StIdle;
                    settle_d = '0;
                end
            endcase
        end

        sel_d = thermo(code_d);
    end

    // Loop state registers; selects are registered alongside the code.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= StIdle;
            settle_q   <= '0;
            code_q     <= CodeInit;
            sel_q      <= thermo(CodeInit);
            rev_q      <= '0;
            last_vld_q <= 1'b0;
            last_dir_q <= DirDn;
            sat_q      <= 1'b0;
            sat_dir_q  <= DirDn;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            code_q     <= code_d;
            sel_q      <= sel_d;
            rev_q      <= rev_d;
            last_vld_q <= last_vld_d;
            last_dir_q <= last_dir_d;
            sat_q      <= sat_d;
            sat_dir_q  <= sat_dir_d;
        end
    end

    assign o_code = code_q;
    assign o_sel  = sel_q;
    assign o_lock = (rev_q == RevMax);
    assign o_sat  = sat_q;

endmodule

// File: tb/tb_u_dly_code_ctrl.sv
// Bench for u_dly_code_ctrl: directed scenarios plus a randomized run, all
// checked every cycle against a behavioural model of the loop.
module tb_u_dly_code_ctrl;

    localparam int N_FINE     = 16;
    localparam int INIT_CODE  = 8;
    localparam int FILT_TH    = 4;
    localparam int SETTLE_CYC = 8;
    localparam int LOCK_REV   = 4;

    localparam int PIdle   = 0;
    localparam int PSettle = 1;
    localparam int PTrack  = 2;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_en;
    logic        i_init;
    logic        i_pd_up;
    logic        i_pd_dn;
    logic [15:0] o_sel;
    logic [4:0]  o_code;
    logic        o_lock;
    logic        o_sat;

    int vectors = 0;
    int miscompares = 0;

    // Model state: code, filter sum, loop phase, settle cycles left,
    // reversal count, last step (+1/-1, 0 = none), saturation and its direction.
    int m_code, m_acc, m_phase, m_left, m_revs, m_last, m_sat, m_sat_dir;

    u_dly_code_ctrl #(
        .N_FINE     (N_FINE),
        .INIT_CODE  (INIT_CODE),
        .FILT_TH    (FILT_TH),
        .SETTLE_CYC (SETTLE_CYC),
        .LOCK_REV   (LOCK_REV)
    ) dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_en    (i_en),
        .i_init  (i_init),
        .i_pd_up (i_pd_up),
        .i_pd_dn (i_pd_dn),
        .o_sel   (o_sel),
        .o_code  (o_code),
        .o_lock  (o_lock),
        .o_sat   (o_sat)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [15:0] exp_sel(input int c);
        longint t;
        t = (longint'(1) << c) - 1;
        return t[15:0];
    endfunction

    task automatic model_reset();
        m_code = INIT_CODE; m_acc = 0; m_phase = PIdle; m_left = 0;
        m_revs = 0; m_last = 0; m_sat = 0; m_sat_dir = 0;
    endtask

    task automatic model_update(input logic en, input logic init, input logic up,
                                input logic dn);
        int d, dir, tgt;
        if (init) begin
            m_code = INIT_CODE; m_acc = 0; m_revs = 0; m_sat = 0; m_last = 0;
            m_phase = en ? PSettle : PIdle; m_left = SETTLE_CYC;
        end else if (!en) begin
            m_phase = PIdle; m_acc = 0; m_revs = 0;
        end else if (m_phase == PIdle) begin
            m_phase = PSettle; m_left = SETTLE_CYC;
        end else if (m_phase == PSettle) begin
            m_left--;
            if (m_left == 0) m_phase = PTrack;
        end else begin
            d = (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
            m_acc += d;
            if (m_acc == FILT_TH || m_acc == -FILT_TH) begin
                dir = (m_acc > 0) ? 1 : -1;
                m_acc = 0;
                tgt = m_code + dir;
                if (tgt < 0 || tgt > N_FINE) begin
                    m_sat = 1; m_sat_dir = dir;
                end else begin
                    m_code = tgt; m_phase = PSettle; m_left = SETTLE_CYC;
                    if (m_last != 0 && m_last != dir)
                        m_revs = (m_revs < LOCK_REV) ? m_revs + 1 : LOCK_REV;
                    else
                        m_revs = 0;
                    m_last = dir;
                    if (m_sat != 0 && m_sat_dir != dir) m_sat = 0;
                end
            end
        end
    endtask

    task automatic check(input string tag);
        logic [4:0]  ec;
        logic [15:0] es;
        logic        el, ea;
        ec = 5'(m_code);
        es = exp_sel(m_code);
        el = (m_revs >= LOCK_REV);
        ea = (m_sat != 0);
        vectors++;
        assert (o_code === ec) else begin
            miscompares++;
            $error("FAIL %s code: got %0d exp %0d", tag, o_code, ec);
        end
        vectors++;
        assert (o_sel === es) else begin
            miscompares++;
            $error("FAIL %s sel: got %h exp %h", tag, o_sel, es);
        end
        vectors++;
        assert (o_lock === el) else begin
            miscompares++;
            $error("FAIL %s lock: got %b exp %b", tag, o_lock, el);
        end
        vectors++;
        assert (o_sat === ea) else begin
            miscompares++;
            $error("FAIL %s sat: got %b exp %b", tag, o_sat, ea);
        end
    endtask

    // Directed check of all outputs against fixed constants.
    task automatic expect_out(input string tag, input int code, input logic [15:0] sel,
                              input logic lock, input logic sat);
        vectors++;
        assert (o_code === 5'(code)) else begin
            miscompares++;
            $error("FAIL %s const code: got %0d exp %0d", tag, o_code, code);
        end
        vectors++;
        assert (o_sel === sel) else begin
            miscompares++;
            $error("FAIL %s const sel: got %h exp %h", tag, o_sel, sel);
        end
        vectors++;
        assert (o_lock === lock) else begin
            miscompares++;
            $error("FAIL %s const lock: got %b exp %b", tag, o_lock, lock);
        end
        vectors++;
        assert (o_sat === sat) else begin
            miscompares++;
            $error("FAIL %s const sat: got %b exp %b", tag, o_sat, sat);
        end
    endtask

    task automatic tick(input logic en, input logic init, input logic up, input logic dn,
                        input string tag);
        i_en = en; i_init = init; i_pd_up = up; i_pd_dn = dn;
        @(posedge i_clk);
        model_update(en, init, up, dn);
        @(negedge i_clk);
        check(tag);
    endtask

    task automatic bound_fail(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: cycle budget expired", tag);
    endtask

    initial begin
        int guard;
        int bias;
        logic r_en, r_init, r_up, r_dn;

        i_rstn = 1'b0; i_en = 1'b0; i_init = 1'b0; i_pd_up = 1'b0; i_pd_dn = 1'b0;
        model_reset();
        repeat (3) @(negedge i_clk);
        expect_out("in_reset", 8, 16'h00FF, 1'b0, 1'b0);
        i_rstn = 1'b1;

        // 1: disabled loop holds reset outputs whatever the PD does.
        for (int i = 0; i < 50; i++)
            tick(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "idle");
        expect_out("idle_end", 8, 16'h00FF, 1'b0, 1'b0);

        // 2: up held: 1 idle + 8 settle cycles, then 4 samples per step.
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, "up_first");
        expect_out("before_step", 8, 16'h00FF, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, "up_first");
        expect_out("first_step", 9, 16'h01FF, 1'b0, 1'b0);
        for (int i = 0; i < 7 * 12; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, "up_run");
        expect_out("top_code", 16, 16'hFFFF, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, "up_sat");
        expect_out("sat_top", 16, 16'hFFFF, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, "sat_hold");

        // 3: re-init, then alternate bursts; each burst is 8 settle + 4 samples.
        tick(1'b1, 1'b1, 1'b1, 1'b0, "init_pulse");
        expect_out("after_init", 8, 16'h00FF, 1'b0, 1'b0);
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < 12; i++)
                tick(1'b1, 1'b0, (b % 2) == 0, (b % 2) == 1, "burst");
            if (b == 3) expect_out("three_rev", 8, 16'h00FF, 1'b0, 1'b0);
        end
        expect_out("locked", 9, 16'h01FF, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, "same_dir");
        expect_out("unlock", 10, 16'h03FF, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, "same_dir2");
        expect_out("unlock2", 11, 16'h07FF, 1'b0, 1'b0);

        // 4: contradictory PD samples in TRACK never step.
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, "to_track");
        for (int i = 0; i < 100; i++) tick(1'b1, 1'b0, 1'b1, 1'b1, "both");
        expect_out("both_end", 11, 16'h07FF, 1'b0, 1'b0);

        // 5: partial accumulation is discarded by a one-cycle disable.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, "acc3");
        tick(1'b0, 1'b0, 1'b1, 1'b0, "en_drop");
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, "reen");
        expect_out("fresh_wait", 11, 16'h07FF, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, "reen");
        expect_out("fresh_step", 12, 16'h0FFF, 1'b0, 1'b0);

        // 6: asynchronous reset mid-SETTLE at code 12.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, "pre_rst");
        #2 i_rstn = 1'b0;
        #1 model_reset();
        expect_out("async_rst", 8, 16'h00FF, 1'b0, 1'b0);
        check("async_rst_model");
        @(posedge i_clk); @(posedge i_clk);
        @(negedge i_clk);
        i_rstn = 1'b1;

        // Drive to the bottom rail, then init clears saturation.
        guard = 0;
        while (m_sat == 0 && guard < 300) begin
            tick(1'b1, 1'b0, 1'b0, 1'b1, "down_run");
            guard++;
        end
        if (guard >= 300) bound_fail("down_run");
        expect_out("sat_bot", 0, 16'h0000, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b1, "init_sat");
        expect_out("init_clr", 8, 16'h00FF, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, "init_settle");
        expect_out("init_settled", 8, 16'h00FF, 1'b0, 1'b0);

        // Randomized run with a drifting PD bias.
        bias = 5;
        for (int i = 0; i < 3000; i++) begin
            if (i % 40 == 0) bias = $urandom_range(0, 10);
            r_en   = ($urandom_range(0, 49) != 0);
            r_init = ($urandom_range(0, 199) == 0);
            r_up   = ($urandom_range(0, 9) < bias);
            r_dn   = ($urandom_range(0, 9) >= bias);
            if ($urandom_range(0, 9) == 0) r_dn = ~r_dn;
            tick(r_en, r_init, r_up, r_dn, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
